// File: rtl/ct_ifu_sfp_wr_ctrl_if.sv
// Request handshake from the LSU and the shared write bus into the SFP entry array.
interface ct_ifu_sfp_wr_ctrl_if #(
    parameter int unsigned IDX_W = 4
);
    localparam int unsigned ENTRY_NUM = 2**IDX_W;

    logic                 lsu_ifu_sfp_req_vld;
    logic                 lsu_ifu_sfp_req_rdy;
    logic [1:0]           lsu_ifu_sfp_req_op;
    logic                 lsu_ifu_sfp_req_type;
    logic [19:0]          lsu_ifu_sfp_req_pc;
    logic [IDX_W-1:0]     lsu_ifu_sfp_req_idx;

    logic [ENTRY_NUM-1:0] entry_write_en;
    logic [ENTRY_NUM-1:0] entry_clk_en;
    logic                 entry_sf_pc_updt_bit;
    logic                 entry_bar_pc_updt_bit;
    logic                 entry_cnt_updt_bit;
    logic [24:0]          entry_write_data;

    modport master (
        output lsu_ifu_sfp_req_vld, lsu_ifu_sfp_req_op, lsu_ifu_sfp_req_type,
               lsu_ifu_sfp_req_pc, lsu_ifu_sfp_req_idx,
        input  lsu_ifu_sfp_req_rdy, entry_write_en, entry_clk_en,
               entry_sf_pc_updt_bit, entry_bar_pc_updt_bit, entry_cnt_updt_bit,
               entry_write_data
    );

    modport slave (
        input  lsu_ifu_sfp_req_vld, lsu_ifu_sfp_req_op, lsu_ifu_sfp_req_type,
               lsu_ifu_sfp_req_pc, lsu_ifu_sfp_req_idx,
        output lsu_ifu_sfp_req_rdy, entry_write_en, entry_clk_en,
               entry_sf_pc_updt_bit, entry_bar_pc_updt_bit, entry_cnt_updt_bit,
               entry_write_data
    );
endinterface

// File: rtl/ct_ifu_sfp_wr_ctrl.sv
// SFP entry-array write controller: 4-deep training FIFO, round-robin allocation
// pointer and a sequenced invalidate sweep, issuing at most one write per cycle.
module ct_ifu_sfp_wr_ctrl #(
    parameter int unsigned IDX_W = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  cp0_ifu_nsfe,
    input  logic                  sfp_vl_pred_en,
    input  logic                  cp0_ifu_sfp_inv,
    ct_ifu_sfp_wr_ctrl_if.slave   sfp_if,
    output logic [IDX_W-1:0]      sfp_alloc_ptr,
    output logic                  sfp_wr_busy
);
    localparam int unsigned ENTRY_NUM  = 2**IDX_W;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    localparam logic [1:0] OP_ALLOC = 2'b00;
    localparam logic [1:0] OP_BAR   = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;

    typedef enum logic {IDLE, INV} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic             typ;
        logic [19:0]      pc;
        logic [IDX_W-1:0] idx;
    } fifo_ent_t;

    state_t               state_q, state_nxt;
    fifo_ent_t            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_nxt, rd_ptr_q, rd_ptr_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [IDX_W-1:0]     alloc_q, alloc_nxt, sweep_q, sweep_nxt;
    logic [ENTRY_NUM-1:0] we_q, we_nxt;
    logic                 sf_q, sf_nxt, bar_q, bar_nxt, cu_q, cu_nxt;
    logic [24:0]          data_q, data_nxt;

    logic      en, full, empty, rdy_c, push, pop;
    fifo_ent_t head, req_ent;

    assign en      = cp0_ifu_nsfe | sfp_vl_pred_en;
    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdy_c   = !full && (state_q == IDLE) && en && !cp0_ifu_sfp_inv;
    assign push    = sfp_if.lsu_ifu_sfp_req_vld && rdy_c;
    // An invalidate in the same cycle drops the head instead of issuing it.
    assign pop     = (state_q == IDLE) && !empty && en && !cp0_ifu_sfp_inv;
    assign head    = fifo_q[rd_ptr_q];
    assign req_ent = '{op:  sfp_if.lsu_ifu_sfp_req_op,
                       typ: sfp_if.lsu_ifu_sfp_req_type,
                       pc:  sfp_if.lsu_ifu_sfp_req_pc,
                       idx: sfp_if.lsu_ifu_sfp_req_idx};

    always_comb begin
        state_nxt  = state_q;
        wr_ptr_nxt = wr_ptr_q + PTR_W'(push);
        rd_ptr_nxt = rd_ptr_q + PTR_W'(pop);
        cnt_nxt    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        alloc_nxt  = alloc_q;
        sweep_nxt  = sweep_q;
        we_nxt     = '0;
        sf_nxt     = 1'b0;
        bar_nxt    = 1'b0;
        cu_nxt     = 1'b0;
        data_nxt   = '0;
        if (!en) begin
            state_nxt  = IDLE;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            cnt_nxt    = '0;
        end else if (cp0_ifu_sfp_inv) begin
            // Start (or restart) the sweep from entry 0 and drop everything queued.
            state_nxt  = INV;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            cnt_nxt    = '0;
            sweep_nxt  = '0;
            alloc_nxt  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        if (head.op == OP_ALLOC) begin
                            we_nxt    = ENTRY_NUM'(1) << alloc_q;
                            sf_nxt    = 1'b1;
                            cu_nxt    = 1'b1;
                            data_nxt  = {head.typ, head.pc, 4'b0010};
                            alloc_nxt = alloc_q + IDX_W'(1);
                        end else if (head.op == OP_BAR) begin
                            we_nxt   = ENTRY_NUM'(1) << head.idx;
                            bar_nxt  = 1'b1;
                            data_nxt = {head.typ, head.pc, 4'b0000};
                        end else begin
                            we_nxt   = ENTRY_NUM'(1) << head.idx;
                            cu_nxt   = 1'b1;
                            data_nxt = {head.typ, head.pc,
                                        (head.op == OP_INC) ? 4'b0100 : 4'b0001};
                        end
                    end
                end
                INV: begin
                    we_nxt    = ENTRY_NUM'(1) << sweep_q;
                    cu_nxt    = 1'b1;
                    data_nxt  = {1'b0, 20'b0, 4'b1000};
                    sweep_nxt = sweep_q + IDX_W'(1);
                    if (sweep_q == IDX_W'(ENTRY_NUM - 1)) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            alloc_q  <= '0;
            sweep_q  <= '0;
            we_q     <= '0;
            sf_q     <= 1'b0;
            bar_q    <= 1'b0;
            cu_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            cnt_q    <= cnt_nxt;
            alloc_q  <= alloc_nxt;
            sweep_q  <= sweep_nxt;
            we_q     <= we_nxt;
            sf_q     <= sf_nxt;
            bar_q    <= bar_nxt;
            cu_q     <= cu_nxt;
            data_q   <= data_nxt;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge forever_cpuclk) begin
        if (push) fifo_q[wr_ptr_q] <= req_ent;
    end

    assign sfp_if.lsu_ifu_sfp_req_rdy   = rdy_c;
    assign sfp_if.entry_write_en        = we_q;
    assign sfp_if.entry_clk_en          = we_q;
    assign sfp_if.entry_sf_pc_updt_bit  = sf_q;
    assign sfp_if.entry_bar_pc_updt_bit = bar_q;
    assign sfp_if.entry_cnt_updt_bit    = cu_q;
    assign sfp_if.entry_write_data      = data_q;
    assign sfp_alloc_ptr                = alloc_q;
    assign sfp_wr_busy                  = (state_q == INV) || !empty;
endmodule

// File: tb/tb_ct_ifu_sfp_wr_ctrl.sv
// Scoreboard bench for ct_ifu_sfp_wr_ctrl: expected writes are queued on acceptance
// and checked in order by a monitor as they appear on the entry write bus.
module tb_ct_ifu_sfp_wr_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       nsfe, vlp, inv;
    logic [3:0] alloc_ptr;
    logic       busy;

    ct_ifu_sfp_wr_ctrl_if #(.IDX_W(4)) sfp_if ();

    ct_ifu_sfp_wr_ctrl #(.IDX_W(4)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .cp0_ifu_nsfe   (nsfe),
        .sfp_vl_pred_en (vlp),
        .cp0_ifu_sfp_inv(inv),
        .sfp_if         (sfp_if),
        .sfp_alloc_ptr  (alloc_ptr),
        .sfp_wr_busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] we;
        logic        sf;
        logic        bar;
        logic        cu;
        logic [24:0] data;
    } exp_t;

    exp_t     q[$];
    int       tests = 0;
    int       fails = 0;
    logic [3:0] m_alloc = 4'd0;

    // Scoreboard monitor: every write must match the oldest expectation; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (sfp_if.entry_write_en !== 16'h0) begin
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write we=%h data=%h required none", sfp_if.entry_write_en, sfp_if.entry_write_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (sfp_if.entry_write_en !== e.we || sfp_if.entry_clk_en !== e.we ||
                        sfp_if.entry_sf_pc_updt_bit !== e.sf || sfp_if.entry_bar_pc_updt_bit !== e.bar ||
                        sfp_if.entry_cnt_updt_bit !== e.cu || sfp_if.entry_write_data !== e.data) begin
                        fails++;
                        $display("FAIL write_bus got we=%h ce=%h sf=%b bar=%b cnt=%b data=%h required we=%h sf=%b bar=%b cnt=%b data=%h",
                                 sfp_if.entry_write_en, sfp_if.entry_clk_en, sfp_if.entry_sf_pc_updt_bit,
                                 sfp_if.entry_bar_pc_updt_bit, sfp_if.entry_cnt_updt_bit, sfp_if.entry_write_data,
                                 e.we, e.sf, e.bar, e.cu, e.data);
                    end
                end
            end else if (sfp_if.entry_clk_en !== 16'h0 || sfp_if.entry_sf_pc_updt_bit !== 1'b0 ||
                         sfp_if.entry_bar_pc_updt_bit !== 1'b0 || sfp_if.entry_cnt_updt_bit !== 1'b0 ||
                         sfp_if.entry_write_data !== 25'h0) begin
                fails++;
                $display("FAIL idle_bus ce=%h sf=%b bar=%b cnt=%b data=%h required all zero",
                         sfp_if.entry_clk_en, sfp_if.entry_sf_pc_updt_bit, sfp_if.entry_bar_pc_updt_bit,
                         sfp_if.entry_cnt_updt_bit, sfp_if.entry_write_data);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b1;
        q.delete();
        m_alloc = 4'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic typ, input logic [19:0] pc, input logic [3:0] idx);
        exp_t e;
        e = '0;
        case (op)
            2'b00: begin e.we = 16'h1 << m_alloc; e.sf = 1'b1; e.cu = 1'b1; e.data = {typ, pc, 4'b0010}; end
            2'b01: begin e.we = 16'h1 << idx; e.bar = 1'b1; e.data = {typ, pc, 4'b0000}; end
            2'b10: begin e.we = 16'h1 << idx; e.cu = 1'b1; e.data = {typ, pc, 4'b0100}; end
            default: begin e.we = 16'h1 << idx; e.cu = 1'b1; e.data = {typ, pc, 4'b0001}; end
        endcase
        return e;
    endfunction

    // Present one request, wait (bounded) for rdy; on acceptance optionally queue its expected write.
    task automatic send(input logic [1:0] op, input logic typ, input logic [19:0] pc, input logic [3:0] idx, input bit expect_wr);
        int n = 0;
        sfp_if.lsu_ifu_sfp_req_vld  = 1'b1;
        sfp_if.lsu_ifu_sfp_req_op   = op;
        sfp_if.lsu_ifu_sfp_req_type = typ;
        sfp_if.lsu_ifu_sfp_req_pc   = pc;
        sfp_if.lsu_ifu_sfp_req_idx  = idx;
        #1;
        while (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1) begin
            tests++; fails++;
            $display("FAIL send_rdy_timeout rdy=%b required 1", sfp_if.lsu_ifu_sfp_req_rdy);
            sfp_if.lsu_ifu_sfp_req_vld = 1'b0;
            return;
        end
        if (expect_wr) begin
            q.push_back(model(op, typ, pc, idx));
            if (op == 2'b00) m_alloc = m_alloc + 4'd1;
        end
        step();
        sfp_if.lsu_ifu_sfp_req_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin step(); n++; end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain pending=%0d required 0", name, q.size());
        end
    endtask

    task automatic push_clears(input int last);
        for (int i = 0; i <= last; i++) q.push_back('{we: 16'h1 << i, sf: 1'b0, bar: 1'b0, cu: 1'b1, data: 25'h8});
    endtask

    task automatic test_reset();
        nsfe = 1'b0; vlp = 1'b0; inv = 1'b0; rst = 1'b1;
        sfp_if.lsu_ifu_sfp_req_vld = 1'b0; sfp_if.lsu_ifu_sfp_req_op = 2'b00;
        sfp_if.lsu_ifu_sfp_req_type = 1'b0; sfp_if.lsu_ifu_sfp_req_pc = '0; sfp_if.lsu_ifu_sfp_req_idx = '0;
        step(); step();
        rst = 1'b0;
        step();
        tests++;
        if (sfp_if.entry_write_en !== 16'h0 || alloc_ptr !== 4'd0 || busy !== 1'b0 || sfp_if.lsu_ifu_sfp_req_rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_disabled we=%h ptr=%0d busy=%b rdy=%b required 0 0 0 0", sfp_if.entry_write_en, alloc_ptr, busy, sfp_if.lsu_ifu_sfp_req_rdy);
        end
        vlp = 1'b1;
        #1;
        tests++;
        if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1) begin
            fails++; $display("FAIL reset_alt_enable rdy=%b required 1", sfp_if.lsu_ifu_sfp_req_rdy);
        end
        vlp = 1'b0; nsfe = 1'b1;
        apply_reset();
        tests++;
        if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1 || alloc_ptr !== 4'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_enabled rdy=%b ptr=%0d busy=%b required 1 0 0", sfp_if.lsu_ifu_sfp_req_rdy, alloc_ptr, busy);
        end
    endtask

    task automatic test_alloc_latency();
        sfp_if.lsu_ifu_sfp_req_vld = 1'b1; sfp_if.lsu_ifu_sfp_req_op = 2'b00;
        sfp_if.lsu_ifu_sfp_req_type = 1'b1; sfp_if.lsu_ifu_sfp_req_pc = 20'hABCDE; sfp_if.lsu_ifu_sfp_req_idx = 4'd9;
        tests++;
        if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1) begin
            fails++; $display("FAIL alloc_rdy rdy=%b required 1", sfp_if.lsu_ifu_sfp_req_rdy);
        end
        q.push_back('{we: 16'h0001, sf: 1'b1, bar: 1'b0, cu: 1'b1, data: 25'h1ABCDE2});
        m_alloc = 4'd1;
        step();
        sfp_if.lsu_ifu_sfp_req_vld = 1'b0;
        tests++;
        if (sfp_if.entry_write_en !== 16'h0 || busy !== 1'b1) begin
            fails++; $display("FAIL alloc_t1 we=%h busy=%b required 0000 1", sfp_if.entry_write_en, busy);
        end
        step();
        tests++;
        if (sfp_if.entry_write_en !== 16'h0001 || sfp_if.entry_write_data !== 25'h1ABCDE2 || alloc_ptr !== 4'd1) begin
            fails++; $display("FAIL alloc_t2 we=%h data=%h ptr=%0d required 0001 1abcde2 1", sfp_if.entry_write_en, sfp_if.entry_write_data, alloc_ptr);
        end
        drain("alloc");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 17; i++) send(2'b00, i[0], 20'h10000 + 20'(i), 4'd0, 1'b1);
        drain("b2b");
        tests++;
        if (alloc_ptr !== 4'd1) begin
            fails++; $display("FAIL b2b_ptr ptr=%0d required 1", alloc_ptr);
        end
    endtask

    task automatic test_bar_inc_dec();
        send(2'b01, 1'b0, 20'h00123, 4'd5, 1'b1);
        send(2'b10, 1'b0, 20'h00123, 4'd5, 1'b1);
        send(2'b11, 1'b1, 20'h00456, 4'd5, 1'b1);
        drain("bar_inc_dec");
        tests++;
        if (alloc_ptr !== m_alloc) begin
            fails++; $display("FAIL bid_ptr ptr=%0d required %0d", alloc_ptr, m_alloc);
        end
    endtask

    task automatic test_inv_flush();
        int n = 0;
        send(2'b00, 1'b0, 20'h11111, 4'd0, 1'b1);
        send(2'b01, 1'b1, 20'h22222, 4'd3, 1'b1);
        send(2'b10, 1'b0, 20'h33333, 4'd7, 1'b1);
        send(2'b11, 1'b1, 20'h44444, 4'd9, 1'b0);
        inv = 1'b1;
        push_clears(15);
        m_alloc = 4'd0;
        step();
        inv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b0 || busy !== 1'b1) begin
                fails++; $display("FAIL inv_rdy_low cyc=%0d rdy=%b busy=%b required 0 1", i, sfp_if.lsu_ifu_sfp_req_rdy, busy);
            end
            step();
        end
        while (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1 && n < 10) begin step(); n++; end
        drain("inv");
        tests++;
        if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1 || alloc_ptr !== 4'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL inv_end rdy=%b ptr=%0d busy=%b required 1 0 0", sfp_if.lsu_ifu_sfp_req_rdy, alloc_ptr, busy);
        end
    endtask

    task automatic test_disable_mid_sweep();
        int n = 0;
        inv = 1'b1;
        push_clears(7);
        step();
        inv = 1'b0;
        while (sfp_if.entry_write_en !== 16'h0080 && n < 40) begin step(); n++; end
        tests++;
        if (sfp_if.entry_write_en !== 16'h0080) begin
            fails++; $display("FAIL dis_reach_idx7 we=%h required 0080", sfp_if.entry_write_en);
        end
        nsfe = 1'b0; vlp = 1'b0;
        #1;
        tests++;
        if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b0) begin
            fails++; $display("FAIL dis_rdy rdy=%b required 0", sfp_if.lsu_ifu_sfp_req_rdy);
        end
        step();
        tests++;
        if (sfp_if.entry_write_en !== 16'h0 || busy !== 1'b0) begin
            fails++; $display("FAIL dis_stop we=%h busy=%b required 0000 0", sfp_if.entry_write_en, busy);
        end
        repeat (3) step();
        nsfe = 1'b1;
        #1;
        tests++;
        if (sfp_if.lsu_ifu_sfp_req_rdy !== 1'b1) begin
            fails++; $display("FAIL dis_reenable rdy=%b required 1", sfp_if.lsu_ifu_sfp_req_rdy);
        end
        repeat (20) step();
        drain("disable");
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        inv = 1'b1;
        push_clears(15);
        step();
        inv = 1'b0;
        while (sfp_if.entry_write_en !== 16'h0008 && n < 40) begin step(); n++; end
        rst = 1'b1;
        q.delete();
        step();
        tests++;
        if (sfp_if.entry_write_en !== 16'h0 || busy !== 1'b0 || alloc_ptr !== 4'd0) begin
            fails++; $display("FAIL rst_mid we=%h busy=%b ptr=%0d required 0000 0 0", sfp_if.entry_write_en, busy, alloc_ptr);
        end
        rst = 1'b0;
        repeat (20) step();
        drain("rst_mid");
    endtask

    initial begin
        test_reset();
        test_alloc_latency();
        test_back_to_back();
        test_bar_inc_dec();
        test_inv_flush();
        test_disable_mid_sweep();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
